// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations, result held until
// cleared. Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module divider_seq #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             op_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        StInit    = 2'b00,
        StOperate = 2'b01,
        StDone    = 2'b11
    } state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     d_q;
    logic                 dz_q;

    logic [WIDTH:0]       trial;
    logic                 fits;
    logic [WIDTH-1:0]     q_step;
    logic [WIDTH-1:0]     r_step;
    logic [WIDTH-1:0]     q_final;
    logic [WIDTH-1:0]     r_final;
    logic [WIDTH-1:0]     dividend_cap;
    logic [WIDTH-1:0]     divisor_cap;

    // One restoring step; the compare keeps the bit shifted out of R.
    always_comb begin
        trial  = {r_q, q_q[WIDTH-1]};
        fits   = (trial >= {1'b0, d_q});
        q_step = {q_q[WIDTH-2:0], fits};
        r_step = fits ? (trial[WIDTH-1:0] - d_q) : trial[WIDTH-1:0];
    end

`ifdef DIV_SIGNED_EN
    logic sign_quo_q;
    logic sign_rem_q;

    always_comb begin
        dividend_cap = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
        divisor_cap  = divisor[WIDTH-1] ? ('0 - divisor) : divisor;
        // A zero divisor keeps the all-ones quotient, i.e. -1.
        q_final      = (sign_quo_q && !dz_q) ? ('0 - q_step) : q_step;
        r_final      = sign_rem_q ? ('0 - r_step) : r_step;
    end
`else
    always_comb begin
        dividend_cap = dividend;
        divisor_cap  = divisor;
        q_final      = q_step;
        r_final      = r_step;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n || op_clear) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            dz_q        <= 1'b0;
            op_done     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StInit: begin
                    op_done     <= 1'b0;
                    quotient    <= '0;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                    if (op_start) begin
                        q_q        <= dividend_cap;
                        d_q        <= divisor_cap;
                        r_q        <= '0;
                        cnt_q      <= '0;
                        dz_q       <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                        sign_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_rem_q <= dividend[WIDTH-1];
`endif
                        state_q    <= StOperate;
                    end
                end
                StOperate: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        q_q     <= q_final;
                        r_q     <= r_final;
                        state_q <= StDone;
                    end else begin
                        q_q <= q_step;
                        r_q <= r_step;
                    end
                end
                StDone: begin
                    // Outputs are registered from the held result, one edge after entry.
                    op_done     <= 1'b1;
                    quotient    <= q_q;
                    remainder   <= r_q;
                    div_by_zero <= dz_q;
                end
                default: begin
                    state_q     <= StInit;
                    op_done     <= 1'b0;
                    quotient    <= '0;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                end
            endcase
        end
    end

endmodule
